eq_scale_sched: RTL and testbench

- Time-multiplexed gain/volume scheduler for the EQ back end.
- Replaces ten parallel band-scale multipliers and two volume multipliers with one shared signed multiplier.
- Sequences 12 multiplies (5 bands × 2 channels, then 2 volume) per audio sample.
- Sits between the five FIR filter outputs and the audio output path. Started once per sample when FIR outputs are stable.

---
 rtl/eq_pkg.sv | 12 +
 rtl/eq_shared_mult.sv | 30 +++
 rtl/eq_scale_sched.sv | 105 ++++++++++
 tb/tb_eq_scale_sched.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// eq_pkg: shared widths, FSM/band enums and 16-bit saturation helper
package eq_pkg;
  localparam int AUD_W = 16;
  localparam int POT_W = 12;
  localparam int ACC_W = 19;
  localparam int PRD_W = 29;
  typedef enum logic [1:0] {IDLE, BAND, VOL, DONE} state_e;
  typedef enum logic [2:0] {LP, B1, B2, B3, HP} band_e;
  function automatic logic signed [AUD_W-1:0] sat16(input logic signed [PRD_W-1:0] x);
    return x > PRD_W'(32767) ? AUD_W'(32767) : x < -PRD_W'(32768) ? AUD_W'(-32768) : x[AUD_W-1:0];
  endfunction
endpackage

// File: rtl/eq_shared_mult.sv
// eq_shared_mult: registered signed 16x13 multiply with band/volume shift select (EQ_SCALE_SAT_EN clamps the term)
module eq_shared_mult
  import eq_pkg::*;
#(
  parameter int BAND_SHIFT = 11,
  parameter int VOL_SHIFT = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [AUD_W-1:0] a,
  input  logic [POT_W-1:0]        g,
  input  logic                    vol,
  output logic signed [AUD_W-1:0] term
);
  logic signed [PRD_W-1:0] prod;
  logic vol_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prod <= '0;
      vol_q <= 1'b0;
    end else begin
      prod <= PRD_W'(a) * PRD_W'($signed({1'b0, g}));
      vol_q <= vol;
    end
`ifdef EQ_SCALE_SAT_EN
  assign term = sat16(vol_q ? prod >>> VOL_SHIFT : prod >>> BAND_SHIFT);
`else
  assign term = AUD_W'(vol_q ? prod >>> VOL_SHIFT : prod >>> BAND_SHIFT);
`endif
endmodule

// File: rtl/eq_scale_sched.sv
// eq_scale_sched: time-multiplexed EQ band/volume scaler on one shared multiplier (EQ_SCALE_SAT_EN enables saturation)
module eq_scale_sched
  import eq_pkg::*;
#(
  parameter int BAND_SHIFT = 11,
  parameter int VOL_SHIFT = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [AUD_W-1:0] lp_lft,
  input  logic signed [AUD_W-1:0] b1_lft,
  input  logic signed [AUD_W-1:0] b2_lft,
  input  logic signed [AUD_W-1:0] b3_lft,
  input  logic signed [AUD_W-1:0] hp_lft,
  input  logic signed [AUD_W-1:0] lp_rht,
  input  logic signed [AUD_W-1:0] b1_rht,
  input  logic signed [AUD_W-1:0] b2_rht,
  input  logic signed [AUD_W-1:0] b3_rht,
  input  logic signed [AUD_W-1:0] hp_rht,
  input  logic [POT_W-1:0]        POT_LP,
  input  logic [POT_W-1:0]        POT_B1,
  input  logic [POT_W-1:0]        POT_B2,
  input  logic [POT_W-1:0]        POT_B3,
  input  logic [POT_W-1:0]        POT_HP,
  input  logic [POT_W-1:0]        VOLUME,
  output logic signed [AUD_W-1:0] aud_out_lft,
  output logic signed [AUD_W-1:0] aud_out_rht,
  output logic                    vld_out,
  output logic                    busy,
  output logic                    ovr
);
  state_e state, nxt;
  band_e band;
  logic [3:0] step;
  logic signed [AUD_W-1:0] smp [10];
  logic [POT_W-1:0] pot [5];
  logic [POT_W-1:0] vol_g, op_g;
  logic signed [ACC_W-1:0] acc_l, acc_r, acc_v;
  logic signed [AUD_W-1:0] op_a, vin, term;
  logic tv, tch, tvol;
  always_ff @(posedge clk)
    if (state == IDLE && start) begin
      smp <= '{lp_lft, b1_lft, b2_lft, b3_lft, hp_lft, lp_rht, b1_rht, b2_rht, b3_rht, hp_rht};
      pot <= '{POT_LP, POT_B1, POT_B2, POT_B3, POT_HP};
      vol_g <= VOLUME;
    end
  always_comb begin
    band = band_e'(step < 4'd5 ? step[2:0] : 3'(step - 4'd5));
    acc_v = step[0] ? acc_r : acc_l;
`ifdef EQ_SCALE_SAT_EN
    vin = sat16(PRD_W'(acc_v));
`else
    vin = AUD_W'(acc_v);
`endif
    op_a = state == VOL ? vin : smp[step];
    op_g = state == VOL ? vol_g : pot[band];
    nxt = state == IDLE ? (start ? BAND : IDLE) :
          state == BAND ? (step == 4'd9 ? VOL : BAND) :
          state == VOL  ? (step[0] ? DONE : VOL) : (vld_out ? IDLE : DONE);
    busy = state != IDLE && !vld_out;
  end
  eq_shared_mult #(.BAND_SHIFT(BAND_SHIFT), .VOL_SHIFT(VOL_SHIFT)) u_mult (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (op_a),
    .g    (op_g),
    .vol  (state == VOL),
    .term (term)
  );
  // tv/tch/tvol tag the product in flight so its term lands one cycle after the multiply
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      step <= '0;
      tv <= 1'b0;
      tch <= 1'b0;
      tvol <= 1'b0;
      acc_l <= '0;
      acc_r <= '0;
      aud_out_lft <= '0;
      aud_out_rht <= '0;
      vld_out <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= nxt;
      step <= (state == IDLE || step == 4'd9 || (state == VOL && step[0])) ? '0 : step + 4'd1;
      tv <= state == BAND || state == VOL;
      tch <= state == VOL ? step[0] : step > 4'd4;
      tvol <= state == VOL;
      vld_out <= tv && tvol && tch;
      if (start && state != IDLE) ovr <= 1'b1;
      if (tv && !tvol && !tch) acc_l <= acc_l + ACC_W'(term);
      if (tv && !tvol && tch) acc_r <= acc_r + ACC_W'(term);
      if (tv && tvol && !tch) acc_l <= ACC_W'(term);
      if (tv && tvol && tch) begin
        aud_out_lft <= AUD_W'(acc_l);
        aud_out_rht <= term;
      end
      if (state == IDLE && start) begin
        acc_l <= '0;
        acc_r <= '0;
      end
    end
endmodule

// File: tb/tb_eq_scale_sched.sv
// tb_eq_scale_sched: randomized self-checking bench for eq_scale_sched against an integer reference model
module tb_eq_scale_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [15:0] bl [5];
  logic signed [15:0] br [5];
  logic [11:0] pot [5];
  logic [11:0] vol;
  logic [15:0] out_l, out_r;
  logic vld_out, busy, ovr;
  logic exp_ovr = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  eq_scale_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .lp_lft(bl[0]), .b1_lft(bl[1]), .b2_lft(bl[2]), .b3_lft(bl[3]), .hp_lft(bl[4]),
    .lp_rht(br[0]), .b1_rht(br[1]), .b2_rht(br[2]), .b3_rht(br[3]), .hp_rht(br[4]),
    .POT_LP(pot[0]), .POT_B1(pot[1]), .POT_B2(pot[2]), .POT_B3(pot[3]), .POT_HP(pot[4]),
    .VOLUME(vol), .aud_out_lft(out_l), .aud_out_rht(out_r),
    .vld_out(vld_out), .busy(busy), .ovr(ovr)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic longint fit(longint v);
`ifdef EQ_SCALE_SAT_EN
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
`else
    return longint'(shortint'(v));
`endif
  endfunction
  function automatic int model(bit r);
    longint s = 0;
    for (int i = 0; i < 5; i++)
      s += fit((longint'(r ? br[i] : bl[i]) * longint'(pot[i])) >>> 11);
    return int'(fit((fit(s) * longint'(vol)) >>> 12));
  endfunction
  task automatic scramble();
    for (int i = 0; i < 5; i++) begin
      bl[i] = 16'($urandom);
      br[i] = 16'($urandom);
      pot[i] = 12'($urandom);
    end
    vol = 12'($urandom);
  endtask
  // xl/xr < 0 means take the expected output from the model; dup > 0 issues a second start at that cycle
  task automatic run(string tag, int dup, int xl, int xr);
    int el, er, k, bad;
    el = xl < 0 ? model(1'b0) : xl;
    er = xr < 0 ? model(1'b1) : xr;
    @(negedge clk);
    start = 1'b1;
    k = 0;
    bad = 0;
    do begin
      @(negedge clk);
      k++;
      start = (k == dup);
      if (k == 1) scramble();
      if (!vld_out && !busy) bad++;
    end while (!vld_out && k < 30);
    check({tag, " latency"}, k, 14);
    check({tag, " busy_gaps"}, bad, 0);
    check({tag, " busy_at_vld"}, 32'(busy), 0);
    check({tag, " out_lft"}, 32'(out_l), el & 'hFFFF);
    check({tag, " out_rht"}, 32'(out_r), er & 'hFFFF);
    check({tag, " ovr"}, 32'(ovr), 32'(exp_ovr));
    @(negedge clk);
    check({tag, " vld_pulse"}, 32'(vld_out), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int extra;
    for (int i = 0; i < 5; i++) begin
      bl[i] = '0;
      br[i] = '0;
      pot[i] = '0;
    end
    vol = '0;
    repeat (3) @(negedge clk);
    check("rst out_lft", 32'(out_l), 0);
    check("rst out_rht", 32'(out_r), 0);
    check("rst vld", 32'(vld_out), 0);
    check("rst busy", 32'(busy), 0);
    check("rst ovr", 32'(ovr), 0);
    rst_n = 1'b1;
    scramble();
    for (int i = 0; i < 5; i++) begin
      bl[i] = 16'h1000;
      pot[i] = 12'h800;
    end
    vol = 12'h800;
    run("unity", 0, 'h2800, -1);
    scramble();
    for (int i = 0; i < 5; i++) begin
      br[i] = -16'sd1000;
      pot[i] = 12'h800;
    end
    vol = 12'hFFF;
    run("neg_rht", 0, -1, 'hEC79);
    scramble();
    for (int i = 0; i < 5; i++) begin
      bl[i] = 16'h7000;
      pot[i] = 12'hFFF;
    end
    vol = 12'hFFF;
`ifdef EQ_SCALE_SAT_EN
    run("sat", 0, 'h7FF7, -1);
`else
    run("wrap", 0, -1, -1);
`endif
    scramble();
    vol = '0;
    run("vol0", 0, 0, 0);
    scramble();
    for (int i = 0; i < 5; i++) begin
      bl[i] = '0;
      br[i] = '0;
    end
    bl[2] = 16'($urandom_range(1, 32767));
    br[2] = -16'(signed'($urandom_range(1, 32767)));
    pot[2] = '0;
    run("potb2_zero", 0, 0, 0);
    repeat (20) begin
      scramble();
      run("rand", 0, -1, -1);
    end
    scramble();
    exp_ovr = 1'b1;
    run("overrun", 5, -1, -1);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (vld_out) extra++;
    end
    check("overrun extra_vld", extra, 0);
    check("overrun ovr_sticky", 32'(ovr), 1);
    scramble();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst out_lft", 32'(out_l), 0);
    check("midrst out_rht", 32'(out_r), 0);
    check("midrst busy", 32'(busy), 0);
    check("midrst ovr", 32'(ovr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (vld_out) extra++;
    end
    check("midrst no_vld", extra, 0);
    exp_ovr = 1'b0;
    scramble();
    run("post_rst", 0, -1, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
